mod_banderas_reg: RTL

Parametrised, registered ALU status-flag unit. It is the next generation of the combinational zero-flag block and sits directly after the ALU result mux. Each accepted result is captured into ZF/SF/CF/OF registers with one cycle of latency. The block also keeps sticky flag accumulators and a saturating counter of consecutive zero results for the control FSM.

---
 rtl/mod_banderas_reg_if.sv | 33 +++
 rtl/mod_banderas_reg.sv | 87 ++++++++
 2 files changed

// File: rtl/mod_banderas_reg_if.sv
// Result/flag bus between the ALU result mux (master) and the registered flag unit (slave).
// Handshake: in_valid qualifies every input for one edge (no backpressure); out_valid pulses one cycle per accepted result.
interface mod_banderas_reg_if #(
  parameter int WIDTH  = 6,
  parameter int ZCNT_W = 4
);
  logic              in_valid;
  logic [WIDTH-1:0]  resultado;
  logic              a_msb;
  logic              b_msb;
  logic              carry_out;
  logic              es_resta;
  logic              clr_sticky;
  logic              out_valid;
  logic              zf;
  logic              sf;
  logic              cf;
  logic              of;
  logic              pf;
  logic [3:0]        sticky;
  logic [ZCNT_W-1:0] zero_run;
  logic              zero_run_sat;

  modport master (
    output in_valid, resultado, a_msb, b_msb, carry_out, es_resta, clr_sticky,
    input  out_valid, zf, sf, cf, of, pf, sticky, zero_run, zero_run_sat
  );

  modport slave (
    input  in_valid, resultado, a_msb, b_msb, carry_out, es_resta, clr_sticky,
    output out_valid, zf, sf, cf, of, pf, sticky, zero_run, zero_run_sat
  );
endinterface

// File: rtl/mod_banderas_reg.sv
// Registered ALU status flags (ZF/SF/CF/OF/PF), sticky accumulators and saturating zero-run counter.
// Optional even-parity flag enabled by defining BANDERA_PF_EN; otherwise pf is tied to 0.
module mod_banderas_reg #(
  parameter int WIDTH  = 6,
  parameter int ZCNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mod_banderas_reg_if.slave  bus
);
  localparam logic [ZCNT_W-1:0] ZMAX = '1;

  logic              n_zf, n_sf, n_cf, n_of, b_eff;
  logic [3:0]        sticky_base;
  logic [ZCNT_W-1:0] zr_next;

  logic              out_valid_q;
  logic              zf_q, sf_q, cf_q, of_q;
  logic [3:0]        sticky_q;
  logic [ZCNT_W-1:0] zero_run_q;
  logic              sat_q;

  always_comb begin
    n_zf  = (bus.resultado == '0);
    n_sf  = bus.resultado[WIDTH-1];
    // subtract feeds inverted B into the adder, so carry inverts into borrow
    n_cf  = bus.carry_out ^ bus.es_resta;
    b_eff = bus.b_msb ^ bus.es_resta;
    n_of  = (bus.a_msb == b_eff) && (n_sf != bus.a_msb);
    sticky_base = bus.clr_sticky ? 4'b0000 : sticky_q;
    zr_next = '0;
    if (n_zf) begin
      zr_next = (zero_run_q == ZMAX) ? ZMAX : zero_run_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      zf_q        <= 1'b0;
      sf_q        <= 1'b0;
      cf_q        <= 1'b0;
      of_q        <= 1'b0;
      sticky_q    <= 4'b0000;
      zero_run_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        zf_q       <= n_zf;
        sf_q       <= n_sf;
        cf_q       <= n_cf;
        of_q       <= n_of;
        sticky_q   <= sticky_base | {n_of, n_cf, n_sf, n_zf};
        zero_run_q <= zr_next;
        sat_q      <= (zr_next == ZMAX);
      end else begin
        sticky_q   <= sticky_base;
      end
    end
  end

`ifdef BANDERA_PF_EN
  logic pf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pf_q <= 1'b0;
    end else if (bus.in_valid) begin
      pf_q <= ~(^bus.resultado);
    end
  end

  assign bus.pf = pf_q;
`else
  assign bus.pf = 1'b0;
`endif

  assign bus.out_valid    = out_valid_q;
  assign bus.zf           = zf_q;
  assign bus.sf           = sf_q;
  assign bus.cf           = cf_q;
  assign bus.of           = of_q;
  assign bus.sticky       = sticky_q;
  assign bus.zero_run     = zero_run_q;
  assign bus.zero_run_sat = sat_q;
endmodule
